// File: rtl/bano_pkg.sv
// bano_pkg -- shared definitions for the batch-normalization stage.
//   Default widths, the per-channel coefficient record and the
//   saturation bound helpers used by bano_shift_pipe and its regfile.
package bano_pkg;

    localparam int BANO_DATA_BW  = 20;
    localparam int BANO_OUT_BW   = 8;
    localparam int BANO_CHANNELS = 4;
    localparam int BANO_SHIFT_BW = 5;
    localparam int BANO_BIAS_BW  = 16;

    // Coefficient record at the default widths.
    typedef struct packed {
        logic [BANO_SHIFT_BW-1:0] shift;
        logic [BANO_BIAS_BW-1:0]  bias;
    } bano_coef_t;

    // Largest value representable in a signed word of 'bits' bits.
    function automatic int bano_sat_max(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    // Smallest value representable in a signed word of 'bits' bits.
    function automatic int bano_sat_min(input int bits);
        return -(1 << (bits - 1));
    endfunction

endpackage

// File: rtl/bano_coef_regfile.sv
// bano_coef_regfile -- per-channel {shift, bias} coefficient storage.
//   Synchronous write (visible from the cycle after the strobe),
//   combinational read. All entries reset to zero (identity transform).
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   we_i, wr_ch_i            write strobe and target channel
//   wr_shift_i, wr_bias_i    coefficient values to write
//   rd_ch_i                  channel to read
//   rd_shift_o, rd_bias_o    coefficients of rd_ch_i (bias is two's complement)
module bano_coef_regfile
    import bano_pkg::*;
#(
    parameter int  CHANNELS       = BANO_CHANNELS,
    parameter int  SHIFT_BITWIDTH = BANO_SHIFT_BW,
    parameter int  BIAS_BITWIDTH  = BANO_BIAS_BW,
    localparam int CH_W           = $clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      we_i,
    input  logic [CH_W-1:0]           wr_ch_i,
    input  logic [SHIFT_BITWIDTH-1:0] wr_shift_i,
    input  logic [BIAS_BITWIDTH-1:0]  wr_bias_i,
    input  logic [CH_W-1:0]           rd_ch_i,
    output logic [SHIFT_BITWIDTH-1:0] rd_shift_o,
    output logic [BIAS_BITWIDTH-1:0]  rd_bias_o
);

    // Same layout as bano_coef_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [SHIFT_BITWIDTH-1:0] shift;
        logic [BIAS_BITWIDTH-1:0]  bias;
    } coef_t;

    coef_t coef_q [CHANNELS];
    coef_t coef_d [CHANNELS];

    always_comb begin
        coef_d = coef_q;
        // Out-of-range channel numbers (non power-of-two CHANNELS) are ignored.
        if (we_i && (int'(wr_ch_i) < CHANNELS)) begin
            coef_d[wr_ch_i] = '{shift: wr_shift_i, bias: wr_bias_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < CHANNELS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            coef_q <= coef_d;
        end
    end

    assign rd_shift_o = coef_q[rd_ch_i].shift;
    assign rd_bias_o  = coef_q[rd_ch_i].bias;

endmodule

// File: rtl/bano_shift_pipe.sv
// bano_shift_pipe -- two-stage batch-normalization pipeline.
//   Stage 1: sum = sext(data) + sext(bias[ch]) (+ rounding constant).
//   Stage 2: arithmetic right shift by shift[ch], saturate to OUT_BITWIDTH.
//   Channel-serial input, round-robin channel counter picks coefficients.
//   Build option: define BANO_ROUNDING_EN for round-half-up; otherwise the
//   shift truncates (floor).
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   enable_i, ready_o, data_i        input handshake and word
//   enable_o, ready_i, data_o        output handshake and normalized word
//   ch_o, last_o                     channel of data_o, data_o is last channel
//   cfg_we_i, cfg_ch_i,
//   cfg_shift_i, cfg_bias_i          coefficient write port
module bano_shift_pipe
    import bano_pkg::*;
#(
    parameter int  DATA_BITWIDTH  = BANO_DATA_BW,
    parameter int  OUT_BITWIDTH   = BANO_OUT_BW,
    parameter int  CHANNELS       = BANO_CHANNELS,
    parameter int  SHIFT_BITWIDTH = BANO_SHIFT_BW,
    parameter int  BIAS_BITWIDTH  = BANO_BIAS_BW,
    localparam int CH_W           = $clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    output logic                      ready_o,
    input  logic [DATA_BITWIDTH-1:0]  data_i,
    output logic                      enable_o,
    input  logic                      ready_i,
    output logic [OUT_BITWIDTH-1:0]   data_o,
    output logic [CH_W-1:0]           ch_o,
    output logic                      last_o,
    input  logic                      cfg_we_i,
    input  logic [CH_W-1:0]           cfg_ch_i,
    input  logic [SHIFT_BITWIDTH-1:0] cfg_shift_i,
    input  logic [BIAS_BITWIDTH-1:0]  cfg_bias_i
);

`ifdef BANO_ROUNDING_EN
    // One extra bit so data + bias + 2^(shift-1) cannot wrap.
    localparam int SUM_W = DATA_BITWIDTH + 2;
`else
    localparam int SUM_W = DATA_BITWIDTH + 1;
`endif

    localparam logic signed [SUM_W-1:0] SAT_HI  = SUM_W'(bano_sat_max(OUT_BITWIDTH));
    localparam logic signed [SUM_W-1:0] SAT_LO  = SUM_W'(bano_sat_min(OUT_BITWIDTH));
    localparam logic [CH_W-1:0]         LAST_CH = CH_W'(CHANNELS - 1);

    logic [CH_W-1:0]           ch_cnt_q, ch_cnt_d;

    logic                      s1_valid_q, s1_valid_d;
    logic signed [SUM_W-1:0]   s1_sum_q, s1_sum_d;
    logic [SHIFT_BITWIDTH-1:0] s1_shift_q, s1_shift_d;
    logic [CH_W-1:0]           s1_ch_q, s1_ch_d;

    logic                      s2_valid_q, s2_valid_d;
    logic [OUT_BITWIDTH-1:0]   s2_data_q, s2_data_d;
    logic [CH_W-1:0]           s2_ch_q, s2_ch_d;
    logic                      s2_last_q, s2_last_d;

    logic [SHIFT_BITWIDTH-1:0] coef_shift;
    logic [BIAS_BITWIDTH-1:0]  coef_bias;

    logic                      s2_adv, s1_adv, accept;
    logic signed [SUM_W-1:0]   data_ext, bias_ext, q_shifted;
    logic [OUT_BITWIDTH-1:0]   sat_val;
`ifdef BANO_ROUNDING_EN
    logic signed [SUM_W-1:0]   round_add;
`endif

    bano_coef_regfile #(
        .CHANNELS       (CHANNELS),
        .SHIFT_BITWIDTH (SHIFT_BITWIDTH),
        .BIAS_BITWIDTH  (BIAS_BITWIDTH)
    ) u_coef (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .we_i       (cfg_we_i),
        .wr_ch_i    (cfg_ch_i),
        .wr_shift_i (cfg_shift_i),
        .wr_bias_i  (cfg_bias_i),
        .rd_ch_i    (ch_cnt_q),
        .rd_shift_o (coef_shift),
        .rd_bias_o  (coef_bias)
    );

    // ready_o depends combinationally on ready_i through s2_adv.
    assign s2_adv  = !s2_valid_q || ready_i;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign ready_o = s1_adv;
    assign accept  = enable_i && s1_adv;

    // Stage 1 arithmetic.
    always_comb begin
        data_ext = {{(SUM_W - DATA_BITWIDTH){data_i[DATA_BITWIDTH-1]}}, data_i};
        bias_ext = {{(SUM_W - BIAS_BITWIDTH){coef_bias[BIAS_BITWIDTH-1]}}, coef_bias};
`ifdef BANO_ROUNDING_EN
        round_add = '0;
        // Shifts beyond DATA_BITWIDTH only produce sign fill, so no rounding there.
        if ((coef_shift != '0) && (int'(coef_shift) <= DATA_BITWIDTH)) begin
            round_add = SUM_W'(1) << (coef_shift - SHIFT_BITWIDTH'(1));
        end
        s1_sum_d_calc: begin end
`endif
    end

    // Stage 2 arithmetic: >>> on a signed operand fills with the sign bit,
    // including for shift amounts wider than the sum.
    always_comb begin
        q_shifted = s1_sum_q >>> s1_shift_q;
        if (q_shifted > SAT_HI) begin
            sat_val = SAT_HI[OUT_BITWIDTH-1:0];
        end else if (q_shifted < SAT_LO) begin
            sat_val = SAT_LO[OUT_BITWIDTH-1:0];
        end else begin
            sat_val = q_shifted[OUT_BITWIDTH-1:0];
        end
    end

    always_comb begin
        ch_cnt_d   = ch_cnt_q;
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_shift_d = s1_shift_q;
        s1_ch_d    = s1_ch_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ch_d    = s2_ch_q;
        s2_last_d  = s2_last_q;

        if (accept) begin
            ch_cnt_d = (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + CH_W'(1);
        end

        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
`ifdef BANO_ROUNDING_EN
                s1_sum_d = data_ext + bias_ext + round_add;
`else
                s1_sum_d = data_ext + bias_ext;
`endif
                s1_shift_d = coef_shift;
                s1_ch_d    = ch_cnt_q;
            end
        end

        // Output registers only change when a new word moves in, so they
        // hold while stalled.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = sat_val;
                s2_ch_d   = s1_ch_q;
                s2_last_d = (s1_ch_q == LAST_CH);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ch_cnt_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            s1_ch_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ch_q    <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            ch_cnt_q   <= ch_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_shift_q <= s1_shift_d;
            s1_ch_q    <= s1_ch_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ch_q    <= s2_ch_d;
            s2_last_q  <= s2_last_d;
        end
    end

    assign enable_o = s2_valid_q;
    assign data_o   = s2_data_q;
    assign ch_o     = s2_ch_q;
    assign last_o   = s2_last_q;

endmodule
